magia_l2_tile_arbiter: RTL and testbench
========================================

// Module: magia_l2_tile_arbiter
// PURPOSE
// - Shares the single L2 request port of the mesh between N_TILES tile-side requesters.
// - Each side uses an OBI-style req/gnt/rvalid protocol.
// - Arbitration is round-robin; responses return in order.
// - A tile-ID FIFO routes each L2 response back to the tile that issued the request.
// - Sits between the tile L2 master ports and the L2 memory/AXI bridge, in both the mesh and the mesh testbench.
// PARAMETERS
// - N_TILES          magia_pkg::N_TILES  number of requesting tiles (>=2)
// - ADDR_W           32                  address width
// - DATA_W           32                  data width; BE width = DATA_W/8
// - MAX_OUTSTANDING  4                   ID FIFO depth = max in-flight L2 transactions (power of 2, >=2)
// PORTS
// - clk_i             in   1                      clock
// - rst_ni            in   1                      asynchronous active-low reset
// - tile_req_i        in   N_TILES                per-tile request
// - tile_gnt_o        out  N_TILES                per-tile grant (one-hot or zero)
// - tile_addr_i       in   N_TILES*ADDR_W         per-tile address
// - tile_we_i         in   N_TILES                per-tile write enable
// - tile_be_i         in   N_TILES*DATA_W/8       per-tile byte enables
// - tile_wdata_i      in   N_TILES*DATA_W         per-tile write data
// - tile_rvalid_o     out  N_TILES                per-tile response valid (one-hot or zero)
// - tile_rdata_o      out  DATA_W                 response data, broadcast to all tiles
// - tile_err_o        out  1                      response error, broadcast, qualified by tile_rvalid_o
// - l2_req_o          out  1                      L2 request
// - l2_gnt_i          in   1                      L2 grant
// - l2_addr_o         out  ADDR_W                 address of the selected tile
// - l2_we_o           out  1                      write enable of the selected tile
// - l2_be_o           out  DATA_W/8               byte enables of the selected tile
// - l2_wdata_o        out  DATA_W                 write data of the selected tile
// - l2_rvalid_i       in   1                      L2 response valid (in order, one per grant)
// - l2_rdata_i        in   DATA_W                 L2 response data
// - l2_err_i          in   1                      L2 response error
// - busy_o            out  1                      ID FIFO not empty
// - proto_err_o       out  1                      sticky: l2_rvalid_i arrived while the FIFO was empty
// BEHAVIOUR
// - Reset: rr_ptr=0; FIFO empty; busy_o=0; proto_err_o=0.
// - Reset: all combinational outputs are 0 while no request or response is active.
// - Winner selection (comb): first i with tile_req_i[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_TILES.
// - l2_req_o = |tile_req_i & !fifo_full; l2_* payload is muxed from the winner (zero if none).
// - A full FIFO blocks l2_req_o even if a pop happens in the same cycle (no bypass).
// - Handshake: tile_gnt_o[w] = l2_req_o & l2_gnt_i (comb, same cycle); zero-cycle grant latency.
// - On handshake: push w into the FIFO; rr_ptr <= (w+1) mod N_TILES.
// - The winner must not change while l2_req_o=1 && !l2_gnt_i.
// - Winner stability is met because tiles hold req and payload until granted (OBI rule).
// - rr_ptr updates only on a handshake.
// - Response: l2_rvalid_i & !empty -> tile_rvalid_o[head]=1 (comb), pop the head.
// - Response: tile_rdata_o = l2_rdata_i; tile_err_o = l2_err_i.
// - Simultaneous push and pop when the FIFO is neither empty nor full: count unchanged, both pointers advance.
// - Same-cycle grant and response for the same tile is legal.
// - l2_rvalid_i & empty: response dropped, tile_rvalid_o=0, proto_err_o <= 1 (cleared only by reset).
// - Pointers wrap mod MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.
// - Reset mid-transaction: FIFO flushed. Late L2 responses then raise proto_err_o.
// - The system must quiesce L2 before releasing rst_ni.
// CONFIGURATION
// - MAGIA_L2_ARB_PERF_EN defined: adds output stall_cnt_o [31:0].
// - stall_cnt_o counts cycles with |tile_req_i && !(l2_req_o && l2_gnt_i).
// - stall_cnt_o saturates at 32'hFFFF_FFFF and resets to 0.
// - MAGIA_L2_ARB_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Setup: N_TILES=4, MAX_OUTSTANDING=4, l2_gnt_i=1, L2 responds 2 cycles after grant with rdata=addr.
// - All 4 tiles req continuously -> grants in order 0,1,2,3,0.
// -   Each tile sees rvalid with rdata equal to its own address, in order.
// - Only tile 2 req, rr_ptr=3 -> tile 2 granted first cycle; rr_ptr becomes 3.
// - l2_gnt_i=0 for 5 cycles with tiles 1,3 requesting -> l2_req_o=1 throughout, no tile_gnt_o.
// -   l2_addr_o stable at tile 1 address; on gnt, tile 1 is granted.
// - L2 withholds responses; tile 0 issues 5 reqs -> 4 grants, then l2_req_o=0 (full).
// -   One rvalid -> tile_rvalid_o=4'b0001; the next cycle l2_req_o=1 again.
// - l2_rvalid_i pulse with FIFO empty -> no tile_rvalid_o; proto_err_o=1 until rst_ni low.
// -   Assert rst_ni low with 2 in flight -> busy_o=0 immediately.
// - PERF_EN: tile 0 req with gnt low for 7 cycles, then granted -> stall_cnt_o=7.

Source files
------------

// File: rtl/magia_l2_tile_arbiter_if.sv
// magia_l2_tile_arbiter_if: tile-side and L2-side OBI signal bundle of the L2 tile arbiter
interface magia_l2_tile_arbiter_if #(
  parameter int N_TILES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [N_TILES-1:0]          tile_req_i, tile_gnt_o, tile_we_i, tile_rvalid_o;
  logic [N_TILES*ADDR_W-1:0]   tile_addr_i;
  logic [N_TILES*DATA_W/8-1:0] tile_be_i;
  logic [N_TILES*DATA_W-1:0]   tile_wdata_i;
  logic [DATA_W-1:0]           tile_rdata_o;
  logic                        tile_err_o;
  logic                        l2_req_o, l2_gnt_i, l2_we_o, l2_rvalid_i, l2_err_i;
  logic [ADDR_W-1:0]           l2_addr_o;
  logic [DATA_W/8-1:0]         l2_be_o;
  logic [DATA_W-1:0]           l2_wdata_o, l2_rdata_i;
  modport slave (
    input  tile_req_i, tile_addr_i, tile_we_i, tile_be_i, tile_wdata_i,
           l2_gnt_i, l2_rvalid_i, l2_rdata_i, l2_err_i,
    output tile_gnt_o, tile_rvalid_o, tile_rdata_o, tile_err_o,
           l2_req_o, l2_addr_o, l2_we_o, l2_be_o, l2_wdata_o
  );
  modport master (
    output tile_req_i, tile_addr_i, tile_we_i, tile_be_i, tile_wdata_i,
           l2_gnt_i, l2_rvalid_i, l2_rdata_i, l2_err_i,
    input  tile_gnt_o, tile_rvalid_o, tile_rdata_o, tile_err_o,
           l2_req_o, l2_addr_o, l2_we_o, l2_be_o, l2_wdata_o
  );
endinterface

// File: rtl/magia_l2_tile_arbiter.sv
// magia_l2_tile_arbiter: round-robin share of one OBI L2 port among N_TILES tiles, responses routed by a tile-ID FIFO
// Define MAGIA_L2_ARB_PERF_EN to add the saturating stall_cnt_o performance counter.
module magia_l2_tile_arbiter #(
  parameter int N_TILES         = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  magia_l2_tile_arbiter_if.slave bus,
  output logic                   busy_o,
  output logic                   proto_err_o
`ifdef MAGIA_L2_ARB_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);
  localparam int IW = $clog2(N_TILES);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, win, win_hi, win_lo;
  logic [N_TILES-1:0] req_hi;
  logic [IW-1:0]      fifo_q [MAX_OUTSTANDING];
  logic [IW-1:0]      fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               err_q, err_d, full, empty, push, pop;

  // Requesters at or above rr_ptr win first; otherwise wrap to the lowest requester.
  always_comb begin
    req_hi = bus.tile_req_i & ~((N_TILES'(1) << rr_ptr_q) - N_TILES'(1));
    win_hi = '0;
    win_lo = '0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      win_hi = req_hi[i] ? IW'(i) : win_hi;
      win_lo = bus.tile_req_i[i] ? IW'(i) : win_lo;
    end
    win = |req_hi ? win_hi : win_lo;
  end

  always_comb begin
    bus.l2_addr_o  = '0;
    bus.l2_we_o    = 1'b0;
    bus.l2_be_o    = '0;
    bus.l2_wdata_o = '0;
    for (int i = 0; i < N_TILES; i++)
      if (bus.tile_req_i[i] && win == IW'(i)) begin
        bus.l2_addr_o  = bus.tile_addr_i[i*ADDR_W +: ADDR_W];
        bus.l2_we_o    = bus.tile_we_i[i];
        bus.l2_be_o    = bus.tile_be_i[i*(DATA_W/8) +: DATA_W/8];
        bus.l2_wdata_o = bus.tile_wdata_i[i*DATA_W +: DATA_W];
      end
  end

  // No bypass: a full FIFO blocks new requests even while a response pops.
  assign full              = cnt_q == (PW+1)'(MAX_OUTSTANDING);
  assign empty             = cnt_q == '0;
  assign bus.l2_req_o      = |bus.tile_req_i & ~full;
  assign push              = bus.l2_req_o & bus.l2_gnt_i;
  assign pop               = bus.l2_rvalid_i & ~empty;
  assign bus.tile_gnt_o    = push ? N_TILES'(1) << win : '0;
  assign bus.tile_rvalid_o = pop ? N_TILES'(1) << fifo_q[rd_q] : '0;
  assign bus.tile_rdata_o  = bus.l2_rdata_i;
  assign bus.tile_err_o    = bus.l2_err_i;
  assign busy_o            = ~empty;
  assign proto_err_o       = err_q;

  always_comb begin
    fifo_d       = fifo_q;
    fifo_d[wr_q] = push ? win : fifo_q[wr_q];
    wr_d         = wr_q + PW'(push);
    rd_d         = rd_q + PW'(pop);
    cnt_d        = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    rr_ptr_d     = push ? (win == IW'(N_TILES - 1) ? '0 : win + IW'(1)) : rr_ptr_q;
    err_d        = err_q | (bus.l2_rvalid_i & empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      fifo_q   <= '{default: '0};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

`ifdef MAGIA_L2_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (|bus.tile_req_i && !push && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_magia_l2_tile_arbiter.sv
// tb_magia_l2_tile_arbiter: directed scoreboard bench for the L2 tile arbiter
module tb_magia_l2_tile_arbiter;
  localparam int N = 4;
  typedef struct { int tile; logic [31:0] data; logic err; } rsp_t;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic auto_rsp = 1'b1, man_rv = 1'b0, man_err = 1'b0;
  logic [31:0] man_rdata = '0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;
  logic busy, proto_err;
  int target [N];
  int granted [N];
  int gq [$];
  rsp_t rq [$];
  int total = 0, bad = 0;
`ifdef MAGIA_L2_ARB_PERF_EN
  logic [31:0] stall_cnt;
`endif

  magia_l2_tile_arbiter_if #(.N_TILES(N), .ADDR_W(32), .DATA_W(32)) bus ();

  magia_l2_tile_arbiter #(.N_TILES(N), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .busy_o(busy), .proto_err_o(proto_err)
`ifdef MAGIA_L2_ARB_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr_of(input int t, input int g);
    return 32'h1000_0000 + 32'(t) * 32'h100 + 32'(g) * 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input bit need_rq);
    int n = 0;
    while ((gq.size() != 0 || (need_rq && rq.size() != 0)) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(gq.size()) + (need_rq ? 64'(rq.size()) : 64'd0), 64'd0);
  endtask

  // Tiles hold req and payload until granted; each grant consumes one request.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.tile_req_i[i]           = target[i] != granted[i];
      bus.tile_we_i[i]            = 1'b0;
      bus.tile_be_i[i*4 +: 4]     = 4'hF;
      bus.tile_addr_i[i*32 +: 32] = addr_of(i, granted[i]);
      bus.tile_wdata_i[i*32 +: 32] = ~addr_of(i, granted[i]);
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.tile_gnt_o[i]) granted[i] <= granted[i] + 1;

  // L2 echoes the address as read data two cycles after the grant.
  always @(posedge clk) begin
    v1 <= auto_rsp && bus.l2_req_o && bus.l2_gnt_i;
    d1 <= bus.l2_addr_o;
    v2 <= v1;
    d2 <= d1;
  end
  assign bus.l2_rvalid_i = auto_rsp ? v2 : man_rv;
  assign bus.l2_rdata_i  = auto_rsp ? d2 : man_rdata;
  assign bus.l2_err_i    = auto_rsp ? 1'b0 : man_err;

  always @(negedge clk) begin
    int t;
    rsp_t r;
    if (rst_ni) begin
      if (bus.tile_gnt_o != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(bus.tile_gnt_o), 64'd0);
        else begin
          t = gq.pop_front();
          chk("gnt_onehot", 64'(bus.tile_gnt_o), 64'd1 << t);
          chk("gnt_addr", 64'(bus.l2_addr_o), 64'(addr_of(t, granted[t])));
          rq.push_back('{t, addr_of(t, granted[t]), 1'b0});
        end
      end
      if (bus.tile_rvalid_o != '0) begin
        if (rq.size() == 0) chk("rsp_unexpected", 64'(bus.tile_rvalid_o), 64'd0);
        else begin
          r = rq.pop_front();
          chk("rsp_onehot", 64'(bus.tile_rvalid_o), 64'd1 << r.tile);
          chk("rsp_rdata", 64'(bus.tile_rdata_o), 64'(r.data));
          chk("rsp_err", 64'(bus.tile_err_o), 64'(r.err));
        end
      end
    end
  end

  initial begin
    int g0;
    bus.l2_gnt_i = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    chk("rst_l2_req", 64'(bus.l2_req_o), 64'd0);
    chk("rst_gnt", 64'(bus.tile_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(bus.tile_rvalid_o), 64'd0);
    chk("rst_addr", 64'(bus.l2_addr_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < N; i++) target[i] += 2;
    gq = {0, 1, 2, 3, 0, 1, 2, 3};
    wait_idle("t1_all_rr", 1'b1);
    target[2]++;
    gq.push_back(2);
    wait_idle("t2_prep", 1'b1);
    target[2]++;
    gq.push_back(2);
    @(negedge clk);
    chk("t2_gnt_first", 64'(bus.tile_gnt_o), 64'b0100);
    wait_idle("t2_only2", 1'b1);
    target[0]++;
    target[3]++;
    gq = {3, 0};
    wait_idle("t2_ptr3", 1'b1);
    bus.l2_gnt_i = 1'b0;
    target[1]++;
    target[3]++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_req_held", 64'(bus.l2_req_o), 64'd1);
      chk("t3_no_gnt", 64'(bus.tile_gnt_o), 64'd0);
      chk("t3_addr_stable", 64'(bus.l2_addr_o), 64'(addr_of(1, granted[1])));
      tick();
    end
    gq = {1, 3};
    bus.l2_gnt_i = 1'b1;
    wait_idle("t3_gnt", 1'b1);
    auto_rsp = 1'b0;
    g0 = granted[0];
    target[0] += 5;
    gq = {0, 0, 0, 0};
    wait_idle("t4_fill", 1'b0);
    @(negedge clk);
    chk("t4_full_req", 64'(bus.l2_req_o), 64'd0);
    chk("t4_full_busy", 64'(busy), 64'd1);
    tick();
    gq.push_back(0);
    man_rv = 1'b1;
    man_rdata = addr_of(0, g0);
    @(negedge clk);
    chk("t4_no_bypass", 64'(bus.l2_req_o), 64'd0);
    chk("t4_rvalid_t0", 64'(bus.tile_rvalid_o), 64'b0001);
    tick();
    man_rv = 1'b0;
    @(negedge clk);
    chk("t4_req_again", 64'(bus.l2_req_o), 64'd1);
    tick();
    if (rq.size() > 1) rq[1].err = 1'b1;
    for (int k = 0; k < 4; k++) begin
      man_rv = 1'b1;
      man_rdata = addr_of(0, g0 + 1 + k);
      man_err = k == 1;
      tick();
    end
    man_rv = 1'b0;
    man_err = 1'b0;
    @(negedge clk);
    chk("t4_drained_busy", 64'(busy), 64'd0);
    chk("t4_rq_empty", 64'(rq.size()), 64'd0);
    tick();
    man_rv = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t5_no_rvalid", 64'(bus.tile_rvalid_o), 64'd0);
    tick();
    man_rv = 1'b0;
    @(negedge clk);
    chk("t5_proto_set", 64'(proto_err), 64'd1);
    repeat (3) tick();
    chk("t5_proto_sticky", 64'(proto_err), 64'd1);
    target[1] += 2;
    gq = {1, 1};
    wait_idle("t6_fill", 1'b0);
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_proto", 64'(proto_err), 64'd0);
    rq.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    man_rv = 1'b1;
    @(negedge clk);
    chk("t6_late_no_rvalid", 64'(bus.tile_rvalid_o), 64'd0);
    tick();
    man_rv = 1'b0;
    @(negedge clk);
    chk("t6_late_proto", 64'(proto_err), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    auto_rsp = 1'b1;
    tick();
    chk("t7_proto_clr", 64'(proto_err), 64'd0);
    target[1]++;
    target[3]++;
    gq = {1, 3};
    wait_idle("t7_ptr_reset", 1'b1);
`ifdef MAGIA_L2_ARB_PERF_EN
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("perf_rst", 64'(stall_cnt), 64'd0);
    bus.l2_gnt_i = 1'b0;
    target[0]++;
    gq = {0};
    repeat (7) tick();
    bus.l2_gnt_i = 1'b1;
    wait_idle("perf_gnt", 1'b1);
    @(negedge clk);
    chk("perf_stall7", 64'(stall_cnt), 64'd7);
`endif
    chk("end_queues", 64'(gq.size()) + 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
